core_inst_sequencer: RTL and testbench

On-chip instruction sequencer for the WS convolution core. It replaces host-driven stimulus with an FSM that emits the 35-bit core instruction word, one word per clock. The word stream runs all kernel positions (weight load, activation load, execute, OFIFO-to-pmem drain) and then the per-output pmem accumulation pass. The block sits between the host handshake (`start`/`done`) and the core's `inst` and `reset` inputs.

---
 rtl/core_inst_sequencer_if.sv | 13 +
 rtl/core_inst_sequencer.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_core_inst_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_inst_sequencer_if.sv
// Host/core-facing signal bundle of the instruction sequencer.
// The master side issues run requests; the slave side is the sequencer itself.
interface core_inst_sequencer_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [34:0] inst;
  logic        core_rst;
  logic        out_valid;

  modport master (output start, input busy, done, inst, core_rst, out_valid);
  modport slave  (input start, output busy, done, inst, core_rst, out_valid);
endinterface

// File: rtl/core_inst_sequencer.sv
// Instruction sequencer for the WS convolution core: one 35-bit word per clock covering
// every kernel position (weights, activations, execute, OFIFO drain) and then the pmem accumulation pass.
module core_inst_sequencer #(
  parameter int row = 8,
  parameter int col = 8,
  parameter int iw  = 6,
  parameter int ksz = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  core_inst_sequencer_if.slave  seq
);

  localparam int len_nij  = iw * iw;
  localparam int len_kij  = ksz * ksz;
  localparam int ow       = iw - ksz + 1;
  localparam int exec_len = len_nij + row + col + 1;
  localparam int KW       = $clog2(ksz);
  localparam int OWW      = $clog2(ow);

  localparam logic [10:0] W_BASE    = 11'h400;
  localparam logic [34:0] IDLE_WORD = 35'h1_800C_0000;
  // Accumulation read steps: next kj is one pmem bank ahead plus one pixel; wrapping kj also moves one row down.
  localparam logic [10:0] STEP_KJ   = 11'(len_nij + 1);
  localparam logic [10:0] STEP_KI   = 11'(len_nij + iw - (ksz - 1));
  localparam logic [10:0] STEP_OY   = 11'(iw - (ow - 1));

  typedef enum logic [3:0] {
    S_IDLE, S_K_RST, S_KW_L0, S_KW_GAP, S_KLOAD, S_K_GAP, S_ACT_L0, S_A_GAP,
    S_EXEC, S_E_STOP, S_OF_PRE, S_PMEM_WR, S_A_CLR, S_A_RD, S_A_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        t_q, t_d;
  logic [KW-1:0]     ki_q, ki_d, kj_q, kj_d;
  logic [OWW-1:0]    ox_q, ox_d, oy_q, oy_d;
  logic [10:0]       w_off_q, w_off_d;     // kij*col
  logic [10:0]       p_base_q, p_base_d;   // kij*len_nij
  logic [10:0]       o_base_q, o_base_d;   // oy*iw + ox
  logic [10:0]       rd_addr_q, rd_addr_d;

  logic [34:0]       inst_q;
  logic              core_rst_q, busy_q, done_q, out_valid_q, drain_q, drain_last_q;
  logic              core_rst_d, drain_d, drain_last_d, launch;

  logic              acc, cen_p, wen_p, cen_x, ofifo_rd, l0_rd, l0_wr, execute, load;
  logic [10:0]       a_p, a_x;
  logic [34:0]       word_d;
  logic              kj_last, last_kij, last_onij;

  assign kj_last   = (kj_q == KW'(ksz - 1));
  assign last_kij  = kj_last && (ki_q == KW'(ksz - 1));
  assign last_onij = (ox_q == OWW'(ow - 1)) && (oy_q == OWW'(ow - 1));

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    t_d          = t_q + 6'd1;
    ki_d         = ki_q;
    kj_d         = kj_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    w_off_d      = w_off_q;
    p_base_d     = p_base_q;
    o_base_d     = o_base_q;
    rd_addr_d    = rd_addr_q;
    launch       = 1'b0;
    core_rst_d   = 1'b0;
    drain_d      = 1'b0;
    drain_last_d = 1'b0;
    acc          = 1'b0;
    cen_p        = 1'b1;
    wen_p        = 1'b1;
    a_p          = '0;
    cen_x        = 1'b1;
    a_x          = '0;
    ofifo_rd     = 1'b0;
    l0_rd        = 1'b0;
    l0_wr        = 1'b0;
    execute      = 1'b0;
    load         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        t_d = '0;
        // busy_q still covers the one idle cycle before done is presented
        if (seq.start && !busy_q) begin
          launch   = 1'b1;
          state_d  = S_K_RST;
          ki_d     = '0;
          kj_d     = '0;
          w_off_d  = '0;
          p_base_d = '0;
        end
      end
      S_K_RST: begin
        core_rst_d = 1'b1;
        state_d    = S_KW_L0;
        t_d        = '0;
      end
      S_KW_L0: begin
        cen_x = 1'b0;
        l0_wr = 1'b1;
        a_x   = W_BASE + w_off_q + 11'(t_q);
        if (t_q == 6'(col - 1)) begin
          state_d = S_KW_GAP;
          t_d     = '0;
        end
      end
      S_KW_GAP: begin
        state_d = S_KLOAD;
        t_d     = '0;
      end
      S_KLOAD: begin
        l0_rd = 1'b1;
        load  = (t_q != 6'd0);
        if (t_q == 6'(col)) begin
          state_d = S_K_GAP;
          t_d     = '0;
        end
      end
      S_K_GAP: begin
        state_d = S_ACT_L0;
        t_d     = '0;
      end
      S_ACT_L0: begin
        cen_x = 1'b0;
        l0_wr = 1'b1;
        a_x   = 11'(t_q);
        if (t_q == 6'(len_nij - 1)) begin
          state_d = S_A_GAP;
          t_d     = '0;
        end
      end
      S_A_GAP: begin
        state_d = S_EXEC;
        t_d     = '0;
      end
      S_EXEC: begin
        l0_rd   = 1'b1;
        execute = (t_q != 6'd0);
        if (t_q == 6'(exec_len - 1)) begin
          state_d = S_E_STOP;
          t_d     = '0;
        end
      end
      S_E_STOP: begin
        state_d = S_OF_PRE;
        t_d     = '0;
      end
      S_OF_PRE: begin
        ofifo_rd = 1'b1;
        state_d  = S_PMEM_WR;
        t_d      = '0;
      end
      S_PMEM_WR: begin
        ofifo_rd = 1'b1;
        cen_p    = 1'b0;
        wen_p    = 1'b0;
        a_p      = p_base_q + 11'(t_q);
        if (t_q == 6'(len_nij - 1)) begin
          t_d      = '0;
          w_off_d  = w_off_q + 11'(col);
          p_base_d = p_base_q + 11'(len_nij);
          if (last_kij) begin
            state_d  = S_A_CLR;
            ox_d     = '0;
            oy_d     = '0;
            o_base_d = '0;
          end else begin
            state_d = S_K_RST;
            if (kj_last) begin
              kj_d = '0;
              ki_d = ki_q + KW'(1);
            end else begin
              kj_d = kj_q + KW'(1);
            end
          end
        end
      end
      S_A_CLR: begin
        core_rst_d = 1'b1;
        state_d    = S_A_RD;
        t_d        = '0;
        ki_d       = '0;
        kj_d       = '0;
        rd_addr_d  = o_base_q;
      end
      S_A_RD: begin
        acc = (t_q != 6'd0);
        if (t_q < 6'(len_kij)) begin
          cen_p     = 1'b0;
          a_p       = rd_addr_q;
          rd_addr_d = rd_addr_q + (kj_last ? STEP_KI : STEP_KJ);
          if (kj_last) begin
            kj_d = '0;
            ki_d = ki_q + KW'(1);
          end else begin
            kj_d = kj_q + KW'(1);
          end
        end else begin
          state_d = S_A_DRAIN;
          t_d     = '0;
        end
      end
      S_A_DRAIN: begin
        drain_d = 1'b1;
        t_d     = '0;
        if (last_onij) begin
          drain_last_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          state_d = S_A_CLR;
          if (ox_q == OWW'(ow - 1)) begin
            ox_d     = '0;
            oy_d     = oy_q + OWW'(1);
            o_base_d = o_base_q + STEP_OY;
          end else begin
            ox_d     = ox_q + OWW'(1);
            o_base_d = o_base_q + 11'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    word_d = {1'b0, acc, cen_p, wen_p, a_p, cen_x, 1'b1, a_x,
              ofifo_rd, 1'b0, 1'b0, l0_rd, l0_wr, execute, load};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      ki_q      <= '0;
      kj_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      w_off_q   <= '0;
      p_base_q  <= '0;
      o_base_q  <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      ki_q      <= ki_d;
      kj_q      <= kj_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      w_off_q   <= w_off_d;
      p_base_q  <= p_base_d;
      o_base_q  <= o_base_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Output stage: the word is registered; out_valid/done trail the drain word by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q       <= IDLE_WORD;
      core_rst_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      drain_q      <= 1'b0;
      drain_last_q <= 1'b0;
    end else begin
      inst_q       <= word_d;
      core_rst_q   <= core_rst_d;
      drain_q      <= drain_d;
      drain_last_q <= drain_last_d;
      out_valid_q  <= drain_q;
      done_q       <= drain_last_q;
      if (launch)            busy_q <= 1'b1;
      else if (drain_last_q) busy_q <= 1'b0;
    end
  end

  assign seq.inst      = inst_q;
  assign seq.core_rst  = core_rst_q;
  assign seq.busy      = busy_q;
  assign seq.done      = done_q;
  assign seq.out_valid = out_valid_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Scoreboard bench for core_inst_sequencer: a loop-nest model of the instruction stream
// feeds an expectation queue that a free-running monitor drains one cycle at a time.
module tb_core_inst_sequencer;

  localparam int          COL     = 8;
  localparam int          IW      = 6;
  localparam int          KSZ     = 3;
  localparam int          OW      = IW - KSZ + 1;
  localparam int          LEN_NIJ = IW * IW;
  localparam int          EXEC_N  = LEN_NIJ + 8 + COL + 1;
  localparam logic [34:0] IDLE_W  = 35'h1_800C_0000;
  // Start accepted at edge N: one latency cycle, 1524 words, then the done cycle.
  localparam int          DONE_AT = 1 + 1524;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  core_inst_sequencer_if bus ();

  core_inst_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .seq   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [34:0] inst;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        out_valid;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [34:0] mkw(bit acc, bit cen_p, bit wen_p, int a_p, bit cen_x, int a_x,
                                      bit ofr, bit l0rd, bit l0wr, bit ex, bit ld);
    logic [34:0] w;
    w        = IDLE_W;
    w[33]    = acc;
    w[32]    = cen_p;
    w[31]    = wen_p;
    w[30:20] = 11'(a_p);
    w[19]    = cen_x;
    w[17:7]  = 11'(a_x);
    w[6]     = ofr;
    w[3]     = l0rd;
    w[2]     = l0wr;
    w[1]     = ex;
    w[0]     = ld;
    return w;
  endfunction

  task automatic push(input logic [34:0] w, input bit cr, input bit bsy, input bit dn, input bit ov);
    exp_t e;
    e.inst      = w;
    e.core_rst  = cr;
    e.busy      = bsy;
    e.done      = dn;
    e.out_valid = ov;
    exp_q.push_back(e);
  endtask

  // Expected per-cycle stream of one run, starting the cycle after start acceptance.
  task automatic model_run();
    int oy, ox;
    push(IDLE_W, 0, 1, 0, 0);
    for (int kij = 0; kij < KSZ * KSZ; kij++) begin
      push(IDLE_W, 1, 1, 0, 0);
      for (int i = 0; i < COL; i++) push(mkw(0, 1, 1, 0, 0, 'h400 + kij * COL + i, 0, 0, 1, 0, 0), 0, 1, 0, 0);
      push(IDLE_W, 0, 1, 0, 0);
      for (int i = 0; i <= COL; i++) push(mkw(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, i > 0), 0, 1, 0, 0);
      push(IDLE_W, 0, 1, 0, 0);
      for (int t = 0; t < LEN_NIJ; t++) push(mkw(0, 1, 1, 0, 0, t, 0, 0, 1, 0, 0), 0, 1, 0, 0);
      push(IDLE_W, 0, 1, 0, 0);
      for (int t = 0; t < EXEC_N; t++) push(mkw(0, 1, 1, 0, 1, 0, 0, 1, 0, t > 0, 0), 0, 1, 0, 0);
      push(IDLE_W, 0, 1, 0, 0);
      push(mkw(0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0), 0, 1, 0, 0);
      for (int t = 0; t < LEN_NIJ; t++) push(mkw(0, 0, 0, kij * LEN_NIJ + t, 1, 0, 1, 0, 0, 0, 0), 0, 1, 0, 0);
    end
    for (int onij = 0; onij < OW * OW; onij++) begin
      oy = onij / OW;
      ox = onij % OW;
      push(IDLE_W, 1, 1, 0, onij > 0);
      for (int j = 0; j < KSZ * KSZ; j++)
        push(mkw(j > 0, 0, 1, j * LEN_NIJ + (oy + j / KSZ) * IW + ox + j % KSZ, 1, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0);
      push(mkw(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0);
      push(IDLE_W, 0, 1, 0, 0);
    end
    push(IDLE_W, 0, 0, 1, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("inst_word", 64'(bus.inst), 64'(e.inst));
        check("ctl{core_rst,busy,done,out_valid}",
              {60'd0, bus.core_rst, bus.busy, bus.done, bus.out_valid},
              {60'd0, e.core_rst, e.busy, e.done, e.out_valid});
      end
    end
  end

  task automatic launch(input bit hold, input int nruns);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check("start_accepted_busy", 64'(bus.busy), 64'd1);
    for (int r = 0; r < nruns; r++) model_run();
    if (!hold) bus.start = 1'b0;
  endtask

  // Waits for done with a cycle budget; cyc counts from the first cycle after acceptance.
  task automatic run_wait(input bit hold, input bit noise, output int cyc, output int nov);
    bit seen;
    seen = 1'b0;
    cyc  = -1;
    nov  = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.out_valid) nov++;
      if (bus.done) begin
        seen = 1'b1;
        cyc  = i;
        if (!hold) bus.start = 1'b0;
        break;
      end
      if (!hold) bus.start = noise ? ($urandom_range(0, 5) == 0) : 1'b0;
    end
    check("done_within_budget", 64'(seen), 64'd1);
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not terminate, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stimulus
    int cyc, nov, wait_n;
    bus.start = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_inst", 64'(bus.inst), 64'(IDLE_W));
    check("reset_ctl{core_rst,busy,done,out_valid}",
          {60'd0, bus.core_rst, bus.busy, bus.done, bus.out_valid}, 64'd0);
    reset = 1'b0;
    repeat ($urandom_range(2, 6)) @(negedge clk);
    check("idle_after_reset_inst", 64'(bus.inst), 64'(IDLE_W));
    check("idle_after_reset_busy", 64'(bus.busy), 64'd0);

    // Run with random start pulses while busy: must neither restart nor stretch the run.
    launch(1'b0, 1);
    run_wait(1'b0, 1'b1, cyc, nov);
    check("run_a_done_cycle", 64'(cyc), 64'(DONE_AT));
    check("run_a_out_valid_pulses", 64'(nov), 64'd16);
    @(negedge clk);
    check("run_a_busy_after_done", 64'(bus.busy), 64'd0);
    repeat ($urandom_range(1, 5)) @(negedge clk);

    // start held high across done relaunches on the following cycle.
    launch(1'b1, 2);
    run_wait(1'b1, 1'b0, cyc, nov);
    check("run_b_done_cycle", 64'(cyc), 64'(DONE_AT));
    check("run_b_out_valid_pulses", 64'(nov), 64'd16);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("run_c_relaunched_busy", 64'(bus.busy), 64'd1);
    run_wait(1'b0, 1'b1, cyc, nov);
    check("run_c_done_cycle", 64'(cyc), 64'(DONE_AT));
    check("run_c_out_valid_pulses", 64'(nov), 64'd16);
    drain_wait();

    // Asynchronous reset somewhere inside the first EXEC phase.
    launch(1'b0, 0);
    for (int i = 0; i < 300 && !bus.inst[1]; i++) @(negedge clk);
    check("exec_reached", 64'(bus.inst[1]), 64'd1);
    wait_n = $urandom_range(0, 40);
    repeat (wait_n) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_inst", 64'(bus.inst), 64'(IDLE_W));
    check("async_reset_ctl{core_rst,busy,done,out_valid}",
          {60'd0, bus.core_rst, bus.busy, bus.done, bus.out_valid}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nov = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.core_rst || bus.inst !== IDLE_W) nov++;
    end
    check("fsm_idle_after_reset_cycles_active", 64'(nov), 64'd0);

    // Full run after the abandoned one.
    launch(1'b0, 1);
    run_wait(1'b0, 1'b1, cyc, nov);
    check("run_d_done_cycle", 64'(cyc), 64'(DONE_AT));
    check("run_d_out_valid_pulses", 64'(nov), 64'd16);
    drain_wait();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
